conv_stream_ctrl: RTL and testbench
===================================

CONV_STREAM_CTRL -- requirements
Module: conv_stream_ctrl

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 128, meaning 16 pixels x 8 bits per beat.
REQ-002 SHALL have parameter BEATS_PER_FRAME, default 16384, meaning beats in one 512x512 frame.
REQ-003 SHALL have parameter PIPE_LAT, default 10, meaning conv kernel advances from conv_din to matching conv_dout (>=2).
REQ-004 SHALL have one clock and an asynchronous active-low reset, named as the codebase does:
- s_axis_aclk  in  1  sole clock, rising edge
- s_axis_aresetn  in  1  asynchronous active-low reset
REQ-005 SHALL have these ports:
- cfg_enable  in  1  permit frame start
- s_axis_tdata  in  WORD_WIDTH  input pixels
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  input end-of-frame marker
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  WORD_WIDTH  output pixels
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last output beat of frame
- m_axis_tready  in  1  output ready
- conv_din  out  WORD_WIDTH  word to kernel
- conv_dout  in  WORD_WIDTH  kernel result
- conv_stall  out  1  high = kernel holds all state
- frame_done  out  1  one-cycle pulse
- err_tlast  out  1  sticky tlast-mismatch flag

Function
REQ-006 SHALL implement FSM states IDLE, RUN, FLUSH.
REQ-007 SHALL transition IDLE->RUN on any cycle with cfg_enable=1.
REQ-008 SHALL define adv = (!m_axis_tvalid | m_axis_tready) & ((RUN & s_axis_tvalid) | FLUSH), and drive conv_stall = !adv combinationally.
REQ-009 SHALL drive s_axis_tready = RUN & (!m_axis_tvalid | m_axis_tready); never assert it in IDLE or FLUSH.
REQ-010 SHALL drive conv_din = s_axis_tdata in RUN and all-zero otherwise.
REQ-011 SHALL keep a PIPE_LAT-bit valid shift register vld that shifts only on adv, inserting 1 on RUN handshakes and 0 on FLUSH advances.
REQ-012 SHALL drive m_axis_tvalid = vld[PIPE_LAT-1] and m_axis_tdata = conv_dout.
REQ-013 SHALL produce the first output with m_axis_tvalid high exactly PIPE_LAT cycles after the first input handshake when there is no stall.
REQ-014 SHALL keep m_axis_tvalid and m_axis_tdata stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-015 SHALL count input handshakes with in_cnt (width clog2(BEATS_PER_FRAME)).
REQ-016 SHALL, on the handshake where in_cnt=BEATS_PER_FRAME-1, clear in_cnt and move RUN->FLUSH.
REQ-017 SHALL set err_tlast if s_axis_tlast differs from (in_cnt==BEATS_PER_FRAME-1) on any input handshake; framing follows in_cnt only, never tlast.
REQ-018 SHALL count PIPE_LAT advances in FLUSH, then go to RUN if cfg_enable=1, else IDLE; the final flush advance coincides with the last output handshake.
REQ-019 SHALL count output handshakes with out_cnt and drive m_axis_tlast = m_axis_tvalid & (out_cnt==BEATS_PER_FRAME-1); out_cnt wraps to 0 after that beat.
REQ-020 SHALL pulse frame_done for one cycle on the handshake of the m_axis_tlast beat.
REQ-021 SHALL let cfg_enable deassertion in RUN or FLUSH complete the current frame, then stop in IDLE.
REQ-022 SHALL keep frames back-to-back with no overlap: no input of frame n+1 is accepted until the flush of frame n completes.

Reset
REQ-023 SHALL, on s_axis_aresetn=0 (asynchronous, at any time including mid-frame), set state=IDLE, clear vld, in_cnt, out_cnt, flush count and err_tlast, and drop the partial frame.
REQ-024 SHALL hold s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, frame_done=0 and conv_stall=1 during reset.
REQ-025 SHALL make err_tlast clearable only by reset.

Verification (BEATS_PER_FRAME=16, PIPE_LAT=10 unless noted)
REQ-026 SHALL cover steady stream: enable=1, tvalid=1, tready=1, 16 beats with tlast on beat 15 -> out tvalid from cycle 10 after first handshake; 16 outputs; tlast and frame_done on 16th; err_tlast=0.
REQ-027 SHALL cover output backpressure: m_axis_tready toggled randomly -> s_axis_tready and conv_stall follow REQ-008/009; output data and order are unchanged; no beat is lost or duplicated.
REQ-028 SHALL cover input bubbles: s_axis_tvalid toggled randomly -> conv_stall=1 on every bubble; output sequence matches the no-bubble run.
REQ-029 SHALL cover tlast errors: tlast sent on beat 7 and omitted on beat 15 -> err_tlast=1 from the beat-7 handshake onward; frame still ends after 16 outputs.
REQ-030 SHALL cover reset mid-frame: reset asserted after 9 inputs -> all outputs at reset values immediately; a following full frame completes correctly.
REQ-031 SHALL cover enable drop: cfg_enable=0 during frame 1 of 2 -> frame 1 completes, FSM returns to IDLE, s_axis_tready=0 until cfg_enable=1.

Source files
------------

// File: rtl/conv_stream_ctrl_if.sv
// Stream and kernel-side signal bundle for conv_stream_ctrl.
// The slave modport is the controller's view; master is the surrounding
// environment (upstream source, downstream sink, conv kernel, config).
interface conv_stream_ctrl_if #(
    parameter int WORD_WIDTH = 128
);
    logic                  cfg_enable;
    logic [WORD_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tlast;
    logic                  s_axis_tready;
    logic [WORD_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic                  m_axis_tready;
    logic [WORD_WIDTH-1:0] conv_din;
    logic [WORD_WIDTH-1:0] conv_dout;
    logic                  conv_stall;
    logic                  frame_done;
    logic                  err_tlast;

    modport slave (
        input  cfg_enable, s_axis_tdata, s_axis_tvalid, s_axis_tlast,
               m_axis_tready, conv_dout,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
               conv_din, conv_stall, frame_done, err_tlast
    );

    modport master (
        output cfg_enable, s_axis_tdata, s_axis_tvalid, s_axis_tlast,
               m_axis_tready, conv_dout,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
               conv_din, conv_stall, frame_done, err_tlast
    );
endinterface

// File: rtl/conv_stream_ctrl.sv
// Frame-level stream controller wrapped around a fixed-latency conv kernel.
// The kernel has no valid path of its own: it advances every cycle that
// conv_stall is low, so a PIPE_LAT-deep valid shift register tracks which
// kernel slots carry real pixels. One frame is BEATS_PER_FRAME input beats;
// after the last beat the pipe is flushed (zeros pushed) before the next
// frame may enter, so frames never overlap inside the kernel.
module conv_stream_ctrl #(
    parameter int WORD_WIDTH      = 128,
    parameter int BEATS_PER_FRAME = 16384,
    parameter int PIPE_LAT        = 10
) (
    input logic               s_axis_aclk,
    input logic               s_axis_aresetn,
    conv_stream_ctrl_if.slave io
);
    localparam int CNT_W = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
    localparam int FL_W  = $clog2(PIPE_LAT);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS_PER_FRAME - 1);
    localparam logic [FL_W-1:0]  LAST_FLUSH = FL_W'(PIPE_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                state;
    logic [PIPE_LAT-1:0]   vld;
    logic [CNT_W-1:0]      in_cnt;
    logic [CNT_W-1:0]      out_cnt;
    logic [FL_W-1:0]       flush_cnt;
    logic                  err_q;

    logic                  in_run;
    logic                  in_flush;
    logic                  out_vld;
    logic                  out_free;
    logic                  adv;
    logic                  in_hs;
    logic                  out_hs;
    logic                  in_last;
    logic                  out_last;
    logic [WORD_WIDTH-1:0] din_sel;

    assign in_run   = (state == RUN);
    assign in_flush = (state == FLUSH);
    assign out_vld  = vld[PIPE_LAT-1];

    // The output slot is free when empty or being taken this cycle.
    assign out_free = !out_vld || io.m_axis_tready;
    assign adv      = out_free && ((in_run && io.s_axis_tvalid) || in_flush);
    assign in_hs    = in_run && io.s_axis_tvalid && out_free;
    assign out_hs   = out_vld && io.m_axis_tready;
    assign in_last  = (in_cnt == LAST_BEAT);
    assign out_last = (out_cnt == LAST_BEAT);

    // Zero feed outside RUN keeps flush beats deterministic in the kernel.
    assign din_sel  = in_run ? io.s_axis_tdata : '0;

    assign io.conv_din      = din_sel;
    assign io.conv_stall    = !adv;
    assign io.s_axis_tready = in_run && out_free;
    assign io.m_axis_tdata  = io.conv_dout;
    assign io.m_axis_tvalid = out_vld;
    assign io.m_axis_tlast  = out_vld && out_last;
    assign io.frame_done    = out_hs && out_last;
    assign io.err_tlast     = err_q;

    // Frame FSM: input beat counting, flush counting and sticky tlast check.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state     <= IDLE;
            in_cnt    <= '0;
            flush_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_cnt    <= '0;
                    flush_cnt <= '0;
                    if (io.cfg_enable) state <= RUN;
                end
                RUN: begin
                    if (in_hs) begin
                        // Framing is owned by in_cnt; tlast is only audited.
                        if (io.s_axis_tlast != in_last) err_q <= 1'b1;
                        if (in_last) begin
                            in_cnt    <= '0;
                            flush_cnt <= '0;
                            state     <= FLUSH;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (adv) begin
                        if (flush_cnt == LAST_FLUSH) begin
                            flush_cnt <= '0;
                            state     <= io.cfg_enable ? RUN : IDLE;
                        end else begin
                            flush_cnt <= flush_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Valid tracking: shift with the kernel; a beat drained during an input
    // bubble (kernel frozen) is retired in place so it is not sent twice.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            vld <= '0;
        end else if (adv) begin
            vld <= {vld[PIPE_LAT-2:0], in_run};
        end else if (out_hs) begin
            vld[PIPE_LAT-1] <= 1'b0;
        end
    end

    // Output beat position within the frame, for tlast and frame_done.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            out_cnt <= '0;
        end else if (out_hs) begin
            out_cnt <= out_last ? '0 : out_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Bench for conv_stream_ctrl: a behavioural kernel plus a queue-based
// reference model (items carry their advance count through the pipe).
module tb_conv_stream_ctrl;
    localparam int W   = 32;
    localparam int BPF = 16;
    localparam int L   = 10;
    localparam logic [W-1:0] KEY = 32'h5a5a_c3c3;

    logic clk;
    logic rst_n;

    conv_stream_ctrl_if #(.WORD_WIDTH(W)) bus ();

    conv_stream_ctrl #(
        .WORD_WIDTH(W), .BEATS_PER_FRAME(BPF), .PIPE_LAT(L)
    ) dut (
        .s_axis_aclk(clk),
        .s_axis_aresetn(rst_n),
        .io(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural kernel: L-stage pipe, frozen while conv_stall is high.
    logic [W-1:0] kst [L];
    always @(posedge clk) begin
        if (!bus.conv_stall) begin
            for (int i = L - 1; i > 0; i--) kst[i] <= kst[i-1];
            kst[0] <= bus.conv_din ^ KEY;
        end
    end
    assign bus.conv_dout = kst[L-1];

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // Source
    int           src_left = 0;
    int           src_beat = 0;
    int           tl_mode  = 0;
    logic [W-1:0] src_data;

    // Observed DUT activity
    int obs_in = 0, obs_out = 0, obs_frames = 0;
    int first_hs = -1, first_vld = -1;

    // Reference model
    int           ph = 0;          // 0 idle, 1 run, 2 flush
    int           m_in = 0, m_out = 0, m_fl = 0;
    bit           m_err = 0;
    logic [W-1:0] q_data[$];
    int           q_age[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph = 0; m_in = 0; m_out = 0; m_fl = 0; m_err = 0;
        q_data.delete(); q_age.delete();
    endtask

    task automatic sample(input bit en);
        bit e_mv, run, fl, free, adv, hs_in, e_last;
        e_mv   = rst_n && q_data.size() > 0 && q_age[0] == L - 1;
        run    = rst_n && ph == 1;
        fl     = rst_n && ph == 2;
        free   = !e_mv || bus.m_axis_tready;
        adv    = free && ((run && bus.s_axis_tvalid) || fl);
        hs_in  = run && bus.s_axis_tvalid && free;
        e_last = e_mv && m_out == BPF - 1;

        chk("m_tvalid",   64'(bus.m_axis_tvalid), 64'(e_mv));
        chk("m_tlast",    64'(bus.m_axis_tlast),  64'(e_last));
        chk("frame_done", 64'(bus.frame_done),    64'(e_last && bus.m_axis_tready));
        chk("s_tready",   64'(bus.s_axis_tready), 64'(run && free));
        chk("conv_stall", 64'(bus.conv_stall),    64'(!adv));
        chk("conv_din",   64'(bus.conv_din),      run ? 64'(bus.s_axis_tdata) : 64'd0);
        chk("err_tlast",  64'(bus.err_tlast),     64'(m_err));
        if (e_mv) chk("m_tdata", 64'(bus.m_axis_tdata), 64'(q_data[0]));

        // Observed handshakes drive the source and the summary counters.
        if (bus.s_axis_tvalid && bus.s_axis_tready) begin
            obs_in++;
            if (first_hs < 0) first_hs = cyc;
            src_left--;
            src_beat = (src_beat + 1) % BPF;
            src_data = $urandom;
        end
        if (bus.m_axis_tvalid && first_vld < 0) first_vld = cyc;
        if (bus.m_axis_tvalid && bus.m_axis_tready) obs_out++;
        if (bus.frame_done) obs_frames++;

        if (rst_n) begin
            if (e_mv && bus.m_axis_tready) begin
                void'(q_data.pop_front());
                void'(q_age.pop_front());
                m_out = (m_out == BPF - 1) ? 0 : m_out + 1;
            end
            if (adv) foreach (q_age[i]) q_age[i]++;
            if (hs_in) begin
                if (bus.s_axis_tlast != (m_in == BPF - 1)) m_err = 1;
                q_data.push_back(bus.s_axis_tdata ^ KEY);
                q_age.push_back(0);
                if (m_in == BPF - 1) begin
                    m_in = 0; m_fl = 0; ph = 2;
                end else begin
                    m_in++;
                end
            end else if (fl && adv) begin
                m_fl++;
                if (m_fl == L) begin
                    m_fl = 0;
                    ph = en ? 1 : 0;
                end
            end else if (ph == 0 && en) begin
                ph = 1;
            end
        end
        cyc++;
    endtask

    // One cycle: drive at negedge, check just after, then cross the edge.
    task automatic tick(input bit en, input int pv, input int pr);
        bus.cfg_enable    = en;
        bus.s_axis_tvalid = (int'($urandom_range(99)) < pv) && src_left > 0;
        bus.s_axis_tdata  = src_data;
        bus.s_axis_tlast  = (tl_mode != 0) ? (src_beat == 7) : (src_beat == BPF - 1);
        bus.m_axis_tready = int'($urandom_range(99)) < pr;
        #1;
        sample(en);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_s_tready",   64'(bus.s_axis_tready), 64'd0);
        chk("rst_m_tvalid",   64'(bus.m_axis_tvalid), 64'd0);
        chk("rst_m_tlast",    64'(bus.m_axis_tlast),  64'd0);
        chk("rst_frame_done", 64'(bus.frame_done),    64'd0);
        chk("rst_conv_stall", 64'(bus.conv_stall),    64'd1);
        chk("rst_err_tlast",  64'(bus.err_tlast),     64'd0);
        model_reset();
        src_left = 0;
        src_beat = 0;
        @(negedge clk);
    endtask

    initial begin
        int b_in, b_out, b_fr;
        rst_n = 1'b0;
        bus.cfg_enable = 1'b0; bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
        bus.s_axis_tdata = '0; bus.m_axis_tready = 1'b0;
        src_data = $urandom;
        for (int i = 0; i < L; i++) kst[i] = '0;
        @(negedge clk);
        repeat (3) tick(1, 100, 100);
        rst_n = 1'b1;
        repeat (2) tick(0, 100, 100);

        // Steady stream, one frame.
        b_out = obs_out; b_fr = obs_frames;
        src_left = 16;
        repeat (40) tick(1, 100, 100);
        chk("t1_latency", 64'(first_vld - first_hs), 64'(L));
        chk("t1_outs",    64'(obs_out - b_out),      64'd16);
        chk("t1_frames",  64'(obs_frames - b_fr),    64'd1);

        // Output backpressure, two frames.
        b_out = obs_out; b_fr = obs_frames;
        src_left = 32;
        repeat (300) tick(1, 100, 50);
        chk("t2_outs",   64'(obs_out - b_out),   64'd32);
        chk("t2_frames", 64'(obs_frames - b_fr), 64'd2);

        // Input bubbles.
        b_out = obs_out; b_fr = obs_frames;
        src_left = 16;
        repeat (200) tick(1, 50, 100);
        chk("t3_outs",   64'(obs_out - b_out),   64'd16);
        chk("t3_frames", 64'(obs_frames - b_fr), 64'd1);

        // Bubbles and backpressure together.
        b_out = obs_out; b_fr = obs_frames;
        src_left = 48;
        repeat (500) tick(1, 60, 60);
        chk("t4_outs",   64'(obs_out - b_out),   64'd48);
        chk("t4_frames", 64'(obs_frames - b_fr), 64'd3);

        // Misplaced tlast: early on beat 7, missing on beat 15.
        b_out = obs_out; b_fr = obs_frames;
        tl_mode = 1;
        src_left = 16;
        repeat (60) tick(1, 100, 100);
        tl_mode = 0;
        chk("t5_err",    64'(bus.err_tlast),     64'd1);
        chk("t5_outs",   64'(obs_out - b_out),   64'd16);
        chk("t5_frames", 64'(obs_frames - b_fr), 64'd1);

        // Reset after 9 inputs, then a clean frame.
        b_in = obs_in;
        src_left = 16;
        for (int k = 0; k < 100 && obs_in - b_in < 9; k++) tick(1, 100, 100);
        chk("t6_reach9", 64'(obs_in - b_in), 64'd9);
        async_reset();
        repeat (3) tick(1, 100, 100);
        rst_n = 1'b1;
        b_out = obs_out; b_fr = obs_frames;
        src_left = 16;
        repeat (50) tick(1, 100, 100);
        chk("t6_outs",   64'(obs_out - b_out),   64'd16);
        chk("t6_frames", 64'(obs_frames - b_fr), 64'd1);

        // Enable dropped inside frame 1 of 2.
        b_in = obs_in; b_fr = obs_frames;
        src_left = 32;
        for (int k = 0; k < 50 && obs_in - b_in < 5; k++) tick(1, 100, 100);
        chk("t7_reach5", 64'(obs_in - b_in), 64'd5);
        repeat (60) tick(0, 100, 100);
        chk("t7_in_held",    64'(obs_in - b_in),     64'd16);
        chk("t7_frames1",    64'(obs_frames - b_fr), 64'd1);
        chk("t7_idle_ready", 64'(bus.s_axis_tready), 64'd0);
        repeat (60) tick(1, 100, 100);
        chk("t7_in_all",  64'(obs_in - b_in),     64'd32);
        chk("t7_frames2", 64'(obs_frames - b_fr), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
